// File: rtl/doce_tl_pkg.sv
// Shared DoCE transaction-layer definitions: one-hot FSM state encoding and
// the byte-count field width helper.
package doce_tl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BODY = 3'b010,
        ST_TAIL = 3'b100
    } tl_state_t;

    // A byte-count field must hold every value 0..DATA_W/8 inclusive
    function automatic int bc_width(input int data_w);
        return $clog2(data_w / 8) + 1;
    endfunction

endpackage

// File: rtl/tl_beat_reg.sv
// Single-beat output register: data, last flag and byte count stay frozen
// while valid_out is held against a stalled downstream.
module tl_beat_reg #(
    parameter int DATA_W = 128,
    parameter int BC_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              ready_in,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic [BC_W-1:0]   load_bytes,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rlast_out,
    output logic [BC_W-1:0]   last_bytes_out,
    output logic              valid_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_out      <= '0;
            rlast_out      <= 1'b0;
            last_bytes_out <= '0;
            valid_out      <= 1'b0;
        end else if (load) begin
            rdata_out      <= load_data;
            rlast_out      <= load_last;
            last_bytes_out <= load_bytes;
            valid_out      <= 1'b1;
        end else if (ready_in) begin
            valid_out      <= 1'b0;
        end
    end

endmodule

// File: rtl/r_hdr_insert_converter.sv
// Read-data header inserter: prepends an HDR_W-bit header to each burst by
// shifting every beat up, emits a tail beat on residue overflow, reports beat counts.
module r_hdr_insert_converter
    import doce_tl_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int HDR_W  = 24,
    parameter int CNT_W  = 9,
    localparam int BC_W  = bc_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic              rlast_in,
    input  logic [BC_W-1:0]   last_bytes_in,
    input  logic [HDR_W-1:0]  config_in,
    input  logic              bypass_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rlast_out,
    output logic [BC_W-1:0]   last_bytes_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  num,
    output logic              num_valid,
    input  logic              num_ready
);

    localparam int B     = DATA_W / 8;
    localparam int H     = HDR_W / 8;
    localparam int LOW_W = DATA_W - HDR_W;

    tl_state_t         state;
    logic [HDR_W-1:0]  residue;
    logic              bypass_q;
    logic [CNT_W-1:0]  count;
    logic [BC_W-1:0]   tail_bytes;

    logic              is_idle;
    logic              is_body;
    logic              is_tail;
    logic              can_load;
    logic              accept;
    logic              use_bypass;
    logic [BC_W-1:0]   lb_eff;
    logic [BC_W:0]     sum_bytes;
    logic              fits;
    logic [HDR_W-1:0]  hdr_src;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] tail_data;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  beat_count;

    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic [BC_W-1:0]   load_bytes;
    logic              publish;
    logic [CNT_W-1:0]  publish_val;
    logic              go_tail;

    assign is_idle  = (state == ST_IDLE);
    assign is_body  = (state == ST_BODY);
    assign is_tail  = (state == ST_TAIL);
    assign can_load = ~valid_out | ready_in;

    // A new burst may only start once the previous count has a free slot
    always_comb begin
        ready_out = 1'b0;
        if (!reset && can_load) begin
            if (is_idle) begin
                ready_out = ~num_valid | num_ready;
            end else if (is_body) begin
                ready_out = 1'b1;
            end
        end
    end

    assign accept = valid_in & ready_out;

    assign use_bypass = is_idle ? bypass_in : bypass_q;
    assign lb_eff     = (last_bytes_in == '0) ? BC_W'(B) : last_bytes_in;
    assign sum_bytes  = {1'b0, lb_eff} + (BC_W + 1)'(H);
    assign fits       = (sum_bytes <= (BC_W + 1)'(B));
    assign hdr_src    = is_idle ? config_in : residue;
    assign shifted    = {rdata_in[LOW_W-1:0], hdr_src};
    assign count_inc  = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    assign beat_count = is_idle ? CNT_W'(1) : count_inc;

    // Residue bytes beyond the tail's valid count come from the input's
    // invalid upper bytes, so they are cleared
    always_comb begin
        tail_data = '0;
        for (int i = 0; i < H; i++) begin
            if (BC_W'(i) < tail_bytes) begin
                tail_data[8*i +: 8] = residue[8*i +: 8];
            end
        end
    end

    always_comb begin
        load        = 1'b0;
        load_data   = shifted;
        load_last   = 1'b0;
        load_bytes  = BC_W'(B);
        publish     = 1'b0;
        publish_val = beat_count;
        go_tail     = 1'b0;
        if (is_tail) begin
            load        = can_load;
            load_data   = tail_data;
            load_last   = 1'b1;
            load_bytes  = tail_bytes;
            publish     = can_load;
            publish_val = count;
        end else if (accept) begin
            load      = 1'b1;
            load_data = use_bypass ? rdata_in : shifted;
            if (rlast_in) begin
                if (use_bypass) begin
                    load_last  = 1'b1;
                    load_bytes = lb_eff;
                    publish    = 1'b1;
                end else if (fits) begin
                    load_last  = 1'b1;
                    load_bytes = sum_bytes[BC_W-1:0];
                    publish    = 1'b1;
                end else begin
                    go_tail    = 1'b1;
                end
            end
        end
    end

    // FSM, residue, burst counter and the count side channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            residue    <= '0;
            bypass_q   <= 1'b0;
            count      <= '0;
            tail_bytes <= '0;
            num        <= '0;
            num_valid  <= 1'b0;
        end else begin
            if (publish) begin
                num       <= publish_val;
                num_valid <= 1'b1;
            end else if (num_ready) begin
                num_valid <= 1'b0;
            end

            if (accept) begin
                count <= beat_count;
                if (!use_bypass) begin
                    residue <= rdata_in[DATA_W-1 -: HDR_W];
                end
                if (is_idle) begin
                    bypass_q <= bypass_in;
                end
                if (!rlast_in) begin
                    state <= ST_BODY;
                end else if (go_tail) begin
                    state      <= ST_TAIL;
                    tail_bytes <= BC_W'(sum_bytes - (BC_W + 1)'(B));
                end else begin
                    state <= ST_IDLE;
                end
            end else if (is_tail && can_load) begin
                state <= ST_IDLE;
            end
        end
    end

    tl_beat_reg #(
        .DATA_W(DATA_W),
        .BC_W  (BC_W)
    ) u_beat_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .ready_in      (ready_in),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_bytes    (load_bytes),
        .rdata_out     (rdata_out),
        .rlast_out     (rlast_out),
        .last_bytes_out(last_bytes_out),
        .valid_out     (valid_out)
    );

endmodule

// File: tb/tb_r_hdr_insert_converter.sv
// Bench for r_hdr_insert_converter: random bursts checked against a byte-stream
// model (header bytes followed by payload bytes, re-chopped into beats).
module tb_r_hdr_insert_converter;

    localparam int DATA_W = 128;
    localparam int HDR_W  = 24;
    localparam int CNT_W  = 9;
    localparam int BC_W   = $clog2(DATA_W / 8) + 1;
    localparam int B      = DATA_W / 8;
    localparam int H      = HDR_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] rdata_in;
    logic              rlast_in;
    logic [BC_W-1:0]   last_bytes_in;
    logic [HDR_W-1:0]  config_in;
    logic              bypass_in;
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] rdata_out;
    logic              rlast_out;
    logic [BC_W-1:0]   last_bytes_out;
    logic              valid_out;
    logic              ready_in;
    logic [CNT_W-1:0]  num;
    logic              num_valid;
    logic              num_ready;

    int total = 0;
    int bad   = 0;
    int stable_bad;
    int exp_num;

    logic [DATA_W-1:0] stim[$];
    logic [DATA_W-1:0] got_data[$];
    logic              got_last[$];
    logic [BC_W-1:0]   got_bytes[$];
    int                got_num[$];
    logic [DATA_W-1:0] exp_data[$];
    logic              exp_last[$];
    logic [BC_W-1:0]   exp_bytes[$];
    bit                exp_full[$];

    r_hdr_insert_converter #(
        .DATA_W(DATA_W),
        .HDR_W (HDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rdata_in      (rdata_in),
        .rlast_in      (rlast_in),
        .last_bytes_in (last_bytes_in),
        .config_in     (config_in),
        .bypass_in     (bypass_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .rdata_out     (rdata_out),
        .rlast_out     (rlast_out),
        .last_bytes_out(last_bytes_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .num           (num),
        .num_valid     (num_valid),
        .num_ready     (num_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_beat();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic gen_stim(input int n);
        stim.delete();
        repeat (n) stim.push_back(rand_beat());
    endtask

    // Reference model: the output is the byte stream {header, payload} cut into
    // B-byte beats; bypass bursts are passed through beat for beat
    task automatic build_expected(input int n, input bit byp, input int lb, input logic [HDR_W-1:0] cfg);
        byte q[$];
        int  lbe;
        int  nb;
        lbe = (lb == 0) ? B : lb;
        exp_data.delete(); exp_last.delete(); exp_bytes.delete(); exp_full.delete();
        exp_num = (n > (2**CNT_W) - 1) ? (2**CNT_W) - 1 : n;
        if (byp) begin
            for (int k = 0; k < n; k++) begin
                exp_data.push_back(stim[k]);
                exp_last.push_back(k == n - 1);
                exp_bytes.push_back(BC_W'((k == n - 1) ? lbe : B));
                exp_full.push_back(1'b1);
            end
        end else begin
            for (int j = 0; j < H; j++) q.push_back(cfg[8*j +: 8]);
            for (int k = 0; k < n; k++)
                for (int j = 0; j < ((k == n - 1) ? lbe : B); j++) q.push_back(stim[k][8*j +: 8]);
            nb = (q.size() + B - 1) / B;
            for (int k = 0; k < nb; k++) begin
                logic [DATA_W-1:0] d;
                int rem;
                d = '0;
                for (int j = 0; j < B; j++) if (k * B + j < q.size()) d[8*j +: 8] = q[k*B + j];
                rem = q.size() - k * B;
                exp_data.push_back(d);
                exp_last.push_back(k == nb - 1);
                exp_bytes.push_back(BC_W'((rem < B) ? rem : B));
                exp_full.push_back(!(k == nb - 1 && nb == n));
            end
        end
    endtask

    // Drives one burst and collects output beats and the published count
    task automatic run_burst(input int n, input bit byp, input int lb, input logic [HDR_W-1:0] cfg,
                             input int stall_pct, input int gap_pct, input bit want_num);
        int bound;
        bound = 20 * n + 200;
        got_data.delete(); got_last.delete(); got_bytes.delete(); got_num.delete();
        stable_bad = 0;
        fork
            begin : driver
                for (int i = 0; i < n; i++) begin
                    bit acc;
                    acc = 1'b0;
                    for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                        @(negedge clk);
                        valid_in = 1'b0;
                    end
                    for (int c = 0; c < bound && !acc; c++) begin
                        @(negedge clk);
                        valid_in      = 1'b1;
                        rdata_in      = stim[i];
                        rlast_in      = (i == n - 1);
                        last_bytes_in = (i == n - 1) ? BC_W'(lb) : BC_W'($urandom_range(B));
                        config_in     = (i == 0) ? cfg : HDR_W'($urandom);
                        bypass_in     = (i == 0) ? byp : ~byp;
                        #1;
                        acc = ready_out;
                    end
                end
                @(negedge clk);
                valid_in = 1'b0;
                rlast_in = 1'b0;
            end
            begin : collector
                bit                done;
                bit                pv;
                bit                pr;
                logic [DATA_W-1:0] pd;
                logic              pl;
                logic [BC_W-1:0]   pb;
                done = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0; pb = '0;
                for (int c = 0; c < bound && !done; c++) begin
                    @(negedge clk);
                    ready_in = ($urandom_range(99) >= stall_pct);
                    #1;
                    if (pv && !pr && (valid_out !== 1'b1 || rdata_out !== pd || rlast_out !== pl || last_bytes_out !== pb))
                        stable_bad++;
                    if (valid_out && ready_in) begin
                        got_data.push_back(rdata_out);
                        got_last.push_back(rlast_out);
                        got_bytes.push_back(last_bytes_out);
                        done = rlast_out;
                    end
                    pv = valid_out; pr = ready_in; pd = rdata_out; pl = rlast_out; pb = last_bytes_out;
                end
                ready_in = 1'b1;
            end
            begin : num_collector
                bit got;
                got = 1'b0;
                for (int c = 0; c < bound && want_num && !got; c++) begin
                    @(negedge clk);
                    #1;
                    if (num_valid && num_ready) begin
                        got_num.push_back(int'(num));
                        got = 1'b1;
                    end
                end
            end
        join
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; rlast_in = 1'b0; rdata_in = '0; last_bytes_in = '0;
        config_in = '0; bypass_in = 1'b0; ready_in = 1'b1; num_ready = 1'b1;
        #12;
        total++;
        if (ready_out !== 1'b0 || valid_out !== 1'b0 || rlast_out !== 1'b0 || rdata_out !== '0 ||
            last_bytes_out !== '0 || num_valid !== 1'b0 || num !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%0h bytes=%0d nv=%b num=%0d expected all 0",
                     ready_out, valid_out, rlast_out, rdata_out, last_bytes_out, num_valid, num);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (ready_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", ready_out);
        end
    endtask

    task automatic test_header_two_beat();
        gen_stim(2);
        run_burst(2, 1'b0, 16, 24'hABCDEF, 0, 0, 1'b1);
        build_expected(2, 1'b0, 16, 24'hABCDEF);
        total++;
        if (got_data.size() != 3) begin
            bad++;
            $display("[TB] FAIL hdr2_beats: got %0d expected 3", got_data.size());
        end else begin
            total++;
            if (got_data[0][23:0] !== 24'hABCDEF) begin
                bad++;
                $display("[TB] FAIL hdr2_header: got %0h expected abcdef", got_data[0][23:0]);
            end
            total++;
            if (got_last[2] !== 1'b1 || got_bytes[2] !== BC_W'(3) || got_data[2][127:24] !== '0) begin
                bad++;
                $display("[TB] FAIL hdr2_tail: got last=%b bytes=%0d upper=%0h expected last=1 bytes=3 upper=0",
                         got_last[2], got_bytes[2], got_data[2][127:24]);
            end
        end
        for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
            logic [DATA_W-1:0] m;
            m = exp_full[k] ? {DATA_W{1'b1}} : ({DATA_W{1'b1}} >> (DATA_W - 8 * int'(exp_bytes[k])));
            total++;
            if ((got_data[k] & m) !== (exp_data[k] & m) || got_last[k] !== exp_last[k] || got_bytes[k] !== exp_bytes[k]) begin
                bad++;
                $display("[TB] FAIL hdr2_beat%0d: got %0h/%b/%0d expected %0h/%b/%0d", k,
                         got_data[k] & m, got_last[k], got_bytes[k], exp_data[k] & m, exp_last[k], exp_bytes[k]);
            end
        end
        total++;
        if (((got_num.size() == 1) ? got_num[0] : -1) != 2) begin
            bad++;
            $display("[TB] FAIL hdr2_num: got %0d values (first %0d) expected 2", got_num.size(),
                     (got_num.size() > 0) ? got_num[0] : -1);
        end
    endtask

    task automatic test_single_beat();
        logic [HDR_W-1:0] cfg;
        cfg = HDR_W'($urandom);
        gen_stim(1);
        run_burst(1, 1'b0, 10, cfg, 0, 0, 1'b1);
        build_expected(1, 1'b0, 10, cfg);
        total++;
        if (got_data.size() != 1 || got_last[0] !== 1'b1 || got_bytes[0] !== BC_W'(13)) begin
            bad++;
            $display("[TB] FAIL single_shape: got beats=%0d last=%b bytes=%0d expected 1/1/13",
                     got_data.size(), (got_data.size() > 0) ? got_last[0] : 1'bx, (got_data.size() > 0) ? got_bytes[0] : '0);
        end else begin
            total++;
            if (got_data[0][103:0] !== exp_data[0][103:0]) begin
                bad++;
                $display("[TB] FAIL single_data: got %0h expected %0h", got_data[0][103:0], exp_data[0][103:0]);
            end
        end
        total++;
        if (((got_num.size() == 1) ? got_num[0] : -1) != 1) begin
            bad++;
            $display("[TB] FAIL single_num: got %0d values expected num 1", got_num.size());
        end
    endtask

    task automatic test_bypass();
        gen_stim(4);
        run_burst(4, 1'b1, 9, HDR_W'($urandom), 0, 20, 1'b1);
        build_expected(4, 1'b1, 9, '0);
        total++;
        if (got_data.size() != 4) begin
            bad++;
            $display("[TB] FAIL bypass_beats: got %0d expected 4", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
            total++;
            if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k] || got_bytes[k] !== exp_bytes[k]) begin
                bad++;
                $display("[TB] FAIL bypass_beat%0d: got %0h/%b/%0d expected %0h/%b/%0d", k,
                         got_data[k], got_last[k], got_bytes[k], exp_data[k], exp_last[k], exp_bytes[k]);
            end
        end
        total++;
        if (((got_num.size() == 1) ? got_num[0] : -1) != 4) begin
            bad++;
            $display("[TB] FAIL bypass_num: got %0d values expected num 4", got_num.size());
        end
    endtask

    task automatic test_backpressure();
        logic [HDR_W-1:0] cfg;
        cfg = HDR_W'($urandom);
        gen_stim(5);
        run_burst(5, 1'b0, 15, cfg, 50, 0, 1'b1);
        build_expected(5, 1'b0, 15, cfg);
        total++;
        if (stable_bad != 0) begin
            bad++;
            $display("[TB] FAIL stall_stable: got %0d changes while stalled expected 0", stable_bad);
        end
        total++;
        if (got_data.size() != exp_data.size()) begin
            bad++;
            $display("[TB] FAIL stall_beats: got %0d expected %0d", got_data.size(), exp_data.size());
        end
        for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
            logic [DATA_W-1:0] m;
            m = exp_full[k] ? {DATA_W{1'b1}} : ({DATA_W{1'b1}} >> (DATA_W - 8 * int'(exp_bytes[k])));
            total++;
            if ((got_data[k] & m) !== (exp_data[k] & m) || got_last[k] !== exp_last[k] || got_bytes[k] !== exp_bytes[k]) begin
                bad++;
                $display("[TB] FAIL stall_beat%0d: got %0h/%b/%0d expected %0h/%b/%0d", k,
                         got_data[k] & m, got_last[k], got_bytes[k], exp_data[k] & m, exp_last[k], exp_bytes[k]);
            end
        end
        total++;
        if (((got_num.size() == 1) ? got_num[0] : -1) != 5) begin
            bad++;
            $display("[TB] FAIL stall_num: got %0d values expected num 5", got_num.size());
        end
    endtask

    task automatic test_num_backpressure();
        logic [HDR_W-1:0] cfg;
        num_ready = 1'b0;
        gen_stim(3);
        run_burst(3, 1'b0, 7, HDR_W'($urandom), 0, 0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (num_valid !== 1'b1 || num !== CNT_W'(3)) begin
            bad++;
            $display("[TB] FAIL numbp_held: got nv=%b num=%0d expected nv=1 num=3", num_valid, num);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            valid_in = 1'b1; rdata_in = rand_beat(); rlast_in = 1'b1; last_bytes_in = BC_W'(4); bypass_in = 1'b0;
            #1;
            total++;
            if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
                bad++;
                $display("[TB] FAIL numbp_blocked: got rdy=%b vld=%b expected 0/0", ready_out, valid_out);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        num_ready = 1'b1;
        #1;
        total++;
        if (ready_out !== 1'b1 || num_valid !== 1'b1 || num !== CNT_W'(3)) begin
            bad++;
            $display("[TB] FAIL numbp_release: got rdy=%b nv=%b num=%0d expected 1/1/3", ready_out, num_valid, num);
        end
        cfg = HDR_W'($urandom);
        gen_stim(2);
        run_burst(2, 1'b0, 2, cfg, 0, 0, 1'b1);
        build_expected(2, 1'b0, 2, cfg);
        total++;
        if (got_data.size() != exp_data.size() || ((got_num.size() == 1) ? got_num[0] : -1) != 2) begin
            bad++;
            $display("[TB] FAIL numbp_next: got beats=%0d nums=%0d expected beats=%0d num 2",
                     got_data.size(), got_num.size(), exp_data.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [HDR_W-1:0] cfg;
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_in = 1'b1; rdata_in = rand_beat(); rlast_in = 1'b0; config_in = HDR_W'($urandom); bypass_in = 1'b0;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b0 || rdata_out !== '0 || rlast_out !== 1'b0 ||
            last_bytes_out !== '0 || num_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got vld=%b rdy=%b data=%0h last=%b bytes=%0d nv=%b expected all 0",
                     valid_out, ready_out, rdata_out, rlast_out, last_bytes_out, num_valid);
        end
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cfg = HDR_W'($urandom);
        gen_stim(3);
        run_burst(3, 1'b0, 5, cfg, 0, 0, 1'b1);
        build_expected(3, 1'b0, 5, cfg);
        total++;
        if (got_data.size() != exp_data.size()) begin
            bad++;
            $display("[TB] FAIL midreset_beats: got %0d expected %0d", got_data.size(), exp_data.size());
        end
        for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
            logic [DATA_W-1:0] m;
            m = exp_full[k] ? {DATA_W{1'b1}} : ({DATA_W{1'b1}} >> (DATA_W - 8 * int'(exp_bytes[k])));
            total++;
            if ((got_data[k] & m) !== (exp_data[k] & m) || got_last[k] !== exp_last[k] || got_bytes[k] !== exp_bytes[k]) begin
                bad++;
                $display("[TB] FAIL midreset_beat%0d: got %0h/%b/%0d expected %0h/%b/%0d", k,
                         got_data[k] & m, got_last[k], got_bytes[k], exp_data[k] & m, exp_last[k], exp_bytes[k]);
            end
        end
        total++;
        if (((got_num.size() == 1) ? got_num[0] : -1) != 3) begin
            bad++;
            $display("[TB] FAIL midreset_num: got %0d values expected num 3", got_num.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int               n;
            int               lb;
            bit               byp;
            logic [HDR_W-1:0] cfg;
            n   = $urandom_range(1, 6);
            lb  = $urandom_range(0, B);
            byp = ($urandom_range(3) == 0);
            cfg = HDR_W'($urandom);
            gen_stim(n);
            run_burst(n, byp, lb, cfg, $urandom_range(0, 60), 30, 1'b1);
            build_expected(n, byp, lb, cfg);
            total++;
            if (got_data.size() != exp_data.size() || stable_bad != 0) begin
                bad++;
                $display("[TB] FAIL rand%0d_beats: got %0d beats, %0d stall changes expected %0d beats, 0 changes",
                         t, got_data.size(), stable_bad, exp_data.size());
            end
            for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
                logic [DATA_W-1:0] m;
                m = exp_full[k] ? {DATA_W{1'b1}} : ({DATA_W{1'b1}} >> (DATA_W - 8 * int'(exp_bytes[k])));
                total++;
                if ((got_data[k] & m) !== (exp_data[k] & m) || got_last[k] !== exp_last[k] || got_bytes[k] !== exp_bytes[k]) begin
                    bad++;
                    $display("[TB] FAIL rand%0d_beat%0d (n=%0d lb=%0d byp=%b): got %0h/%b/%0d expected %0h/%b/%0d",
                             t, k, n, lb, byp, got_data[k] & m, got_last[k], got_bytes[k],
                             exp_data[k] & m, exp_last[k], exp_bytes[k]);
                end
            end
            total++;
            if (((got_num.size() == 1) ? got_num[0] : -1) != exp_num) begin
                bad++;
                $display("[TB] FAIL rand%0d_num: got %0d values (first %0d) expected %0d", t, got_num.size(),
                         (got_num.size() > 0) ? got_num[0] : -1, exp_num);
            end
        end
    endtask

    task automatic test_saturation();
        logic [HDR_W-1:0] cfg;
        cfg = HDR_W'($urandom);
        gen_stim(520);
        run_burst(520, 1'b0, 16, cfg, 0, 0, 1'b1);
        build_expected(520, 1'b0, 16, cfg);
        total++;
        if (got_data.size() != exp_data.size()) begin
            bad++;
            $display("[TB] FAIL sat_beats: got %0d expected %0d", got_data.size(), exp_data.size());
        end
        total++;
        if (((got_num.size() == 1) ? got_num[0] : -1) != exp_num) begin
            bad++;
            $display("[TB] FAIL sat_num: got %0d values (first %0d) expected %0d", got_num.size(),
                     (got_num.size() > 0) ? got_num[0] : -1, exp_num);
        end
    endtask

    initial begin
        test_reset();
        test_header_two_beat();
        test_single_beat();
        test_bypass();
        test_backpressure();
        test_num_backpressure();
        test_reset_mid_burst();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
